uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Shares one UART transmitter among NREQ byte-producing requesters. It uses round-robin arbitration with an optional per-requester lock, so a multi-byte message is sent without interleaving. It drives the UART's DATAI/WR inputs and tracks its BUSY output. A watchdog flags a UART that never accepts a byte. The block sits between the system-side byte sources and the UART instance, in the same CLOCK/RESET_N domain.

Parameters:
NREQ, 4, number of requesters (2..16)
N, 8, data width; must equal the UART's N
TIMEOUT, 64, cycles allowed between the WR pulse and BUSY rising before an error is raised (≥2)

Ports:
CLOCK  in  1  system clock
RESET_N  in  1  reset; asynchronous, active-low
REQ  in  NREQ  per-requester byte request; held high until the matching ACK
LOCK  in  NREQ  per-requester keep-grant flag, sampled at acceptance
DATA  in  NREQ*N  requester i byte at [i*N +: N]; held stable while REQ[i] is high
ACK  out  NREQ  one-cycle pulse; the byte of requester i was accepted by the UART
GRANT_ID  out  clog2(NREQ)  index of the current or last granted requester
UART_DATAI  out  N  byte presented to the UART
UART_WR  out  1  one-cycle write strobe to the UART
UART_BUSY  in  1  UART BUSY output
ERR  out  1  sticky timeout flag
ERR_CLR  in  1  clears ERR

Behaviour:
- Reset (async, immediate): UART_WR=0, UART_DATAI=0, ACK=0, GRANT_ID=0, ERR=0, lock invalid, last_grant=NREQ-1 (requester 0 has first priority), state IDLE.
- States: IDLE, WAIT_ACCEPT, WAIT_DONE.
- IDLE: a grant needs UART_BUSY=0 and a selected requester.
  - Selection with lock valid: if REQ[owner]=1, pick owner.
  - If REQ[owner]=0 and LOCK[owner]=1, hold: no grant to anyone.
  - If REQ[owner]=0 and LOCK[owner]=0, release the lock this cycle and fall to round-robin.
  - Round-robin: first REQ[i]=1 scanning from (last_grant+1) mod NREQ upward with wrap.
  - On grant at edge E0: UART_DATAI<=DATA[i], GRANT_ID<=i, last_grant<=i, UART_WR<=1, timer<=0, go WAIT_ACCEPT.
- WAIT_ACCEPT:
  - UART_WR is forced 0 from edge E1, so WR is exactly one cycle wide.
  - UART_BUSY=1 sampled: ACK[GRANT_ID] pulses one cycle. Lock valid/owner <= LOCK[GRANT_ID] (owner=GRANT_ID). Go WAIT_DONE.
  - Otherwise timer++. When timer reaches TIMEOUT-1: ERR<=1, no ACK, lock cleared, go IDLE. last_grant keeps the failed index, so it drops to lowest priority.
  - Best-case ACK: after edge E2 (REQ sampled at E0).
- WAIT_DONE: stay until UART_BUSY=0, then IDLE. The earliest next WR is two cycles after BUSY falls.
- A requester dropping REQ after grant does not cancel the byte; the ACK still pulses.
- ERR: set by timeout, cleared by ERR_CLR. Set wins if both occur in the same cycle.
- UART_BUSY high in IDLE (external transfer) blocks all grants.
- Only one ACK bit is ever high; ACK is never asserted without a preceding UART_WR.
- DATA/REQ are sampled only in IDLE; changes in other states are ignored.

Decomposition:
- Shared package uart_pkg:
  - state enum (IDLE, WAIT_ACCEPT, WAIT_DONE)
  - clog2 function
  - UART default constants (N=8, BaudRate, RefFrequency)
- One sub-module, uart_rr_pick: combinational rotating-priority picker.
  - Inputs: REQ vector and last_grant.
  - Outputs: found flag and index.
  - Reusable by a future RX dispatcher.

Test Plan:
1. REQ[1]=1, DATA[1]=0x5A, real UART (10 MHz / 9600) -> single UART_WR pulse, UART_DATAI=0x5A, GRANT_ID=1, one ACK[1] pulse when BUSY rises; TX frame carries 0x5A; no second WR before BUSY falls.
2. REQ=4'b1111 continuously, DATA=0x10,0x11,0x12,0x13 (re-armed after each ACK) -> grant order 0,1,2,3,0, one byte per UART frame.
3. REQ[0]=1; requester 2 sends 0xA1,0xA2,0xA3 with LOCK[2]=1, then LOCK[2]=0 on the last byte -> order 2,2,2,0; a REQ[2] gap with LOCK[2]=1 stalls requester 0.
4. Stub UART with BUSY stuck 0, REQ[3]=1 -> ERR=1 exactly TIMEOUT cycles after WR, no ACK; with REQ[0]=1 also pending, the next grant goes to 0; ERR_CLR clears ERR; ERR_CLR in the timeout cycle leaves ERR=1.
5. Assert RESET_N=0 mid-WAIT_DONE -> UART_WR, ACK, ERR, GRANT_ID are 0 without a clock edge; after release with REQ=4'b1010, the first grant goes to requester 1.
6. External BUSY=1 while REQ[2]=1 -> no UART_WR until BUSY=0, then WR within 1 cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, defaults and helpers for the TX arbiter and its picker.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_ACCEPT, WAIT_DONE} arb_state_e;
    localparam int N_DEFAULT    = 8;
    localparam int BaudRate     = 9600;
    localparam int RefFrequency = 10_000_000;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester and UART-side signals of the shared transmitter arbiter.
interface uart_tx_arbiter_if import uart_pkg::*; #(parameter int NREQ = 4, parameter int N = 8);
    localparam int W = clog2(NREQ);
    logic [NREQ-1:0]   REQ;
    logic [NREQ-1:0]   LOCK;
    logic [NREQ*N-1:0] DATA;
    logic [NREQ-1:0]   ACK;
    logic [W-1:0]      GRANT_ID;
    logic [N-1:0]      UART_DATAI;
    logic              UART_WR;
    logic              UART_BUSY;
    logic              ERR;
    logic              ERR_CLR;
    modport master (output REQ, LOCK, DATA, UART_BUSY, ERR_CLR,
                    input  ACK, GRANT_ID, UART_DATAI, UART_WR, ERR);
    modport slave  (input  REQ, LOCK, DATA, UART_BUSY, ERR_CLR,
                    output ACK, GRANT_ID, UART_DATAI, UART_WR, ERR);
endinterface

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: rotating-priority picker, first request after last_grant with wrap.
module uart_rr_pick import uart_pkg::*; #(
    parameter int NREQ = 4,
    localparam int W = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [W-1:0]    last_grant,
    output logic            found,
    output logic [W-1:0]    idx
);
    logic [W-1:0] j;
    // Scan farthest-first so the closest requester after last_grant is assigned last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j = W'((int'(last_grant) + k) % NREQ);
            if (req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter with per-requester lock and accept watchdog.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int NREQ    = 4,
    parameter int N       = 8,
    parameter int TIMEOUT = 64
) (
    input logic CLOCK,
    input logic RESET_N,
    uart_tx_arbiter_if.slave bus
);
    localparam int W  = clog2(NREQ);
    localparam int TW = clog2(TIMEOUT);
    arb_state_e state_q, state_d;
    logic [W-1:0] last_q, last_d, grant_q, grant_d, owner_q, owner_d, pick_idx, sel;
    logic lock_q, lock_d, wr_q, wr_d, err_q, err_d, pick_found, own_req, own_hold, grant;
    logic [N-1:0] datai_q, datai_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [TW-1:0] timer_q, timer_d;
    uart_rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (bus.REQ),
        .last_grant (last_q),
        .found      (pick_found),
        .idx        (pick_idx)
    );
    assign own_req  = lock_q && bus.REQ[owner_q];
    assign own_hold = lock_q && !bus.REQ[owner_q] && bus.LOCK[owner_q];
    assign sel      = own_req ? owner_q : pick_idx;
    assign grant    = !bus.UART_BUSY && (own_req || (!own_hold && pick_found));
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        owner_d = owner_q;
        lock_d  = lock_q;
        datai_d = datai_q;
        timer_d = timer_q;
        wr_d    = 1'b0;
        ack_d   = '0;
        err_d   = err_q & ~bus.ERR_CLR;
        case (state_q)
            IDLE: begin
                if (lock_q && !bus.REQ[owner_q] && !bus.LOCK[owner_q]) lock_d = 1'b0;
                if (grant) begin
                    datai_d = bus.DATA[int'(sel)*N +: N];
                    grant_d = sel;
                    last_d  = sel;
                    wr_d    = 1'b1;
                    timer_d = '0;
                    state_d = WAIT_ACCEPT;
                end
            end
            WAIT_ACCEPT: begin
                if (bus.UART_BUSY) begin
                    ack_d   = NREQ'(1) << grant_q;
                    lock_d  = bus.LOCK[grant_q];
                    owner_d = grant_q;
                    state_d = WAIT_DONE;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    // last_grant keeps the failed index so it drops to lowest priority.
                    err_d   = 1'b1;
                    lock_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_DONE: state_d = bus.UART_BUSY ? WAIT_DONE : IDLE;
            default:   state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            last_q  <= W'(NREQ - 1);
            grant_q <= '0;
            owner_q <= '0;
            lock_q  <= 1'b0;
            datai_q <= '0;
            timer_q <= '0;
            wr_q    <= 1'b0;
            ack_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            lock_q  <= lock_d;
            datai_q <= datai_d;
            timer_q <= timer_d;
            wr_q    <= wr_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end
    assign bus.ACK        = ack_q;
    assign bus.GRANT_ID   = grant_q;
    assign bus.UART_DATAI = datai_q;
    assign bus.UART_WR    = wr_q;
    assign bus.ERR        = err_q;
endmodule
